ann_mem_arbiter: RTL and testbench

ANN_MEM_ARBITER -- requirements
Module: ann_mem_arbiter

---
 rtl/ann_mem_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_ann_mem_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ann_mem_arbiter.sv
// ann_mem_arbiter
// Two-port (host / NPU) arbiter in front of a single-port memory with a
// one-cycle read latency. Grants are combinational from the requests and the
// arbiter state. The winner's address/data go to the memory in the same cycle.
// Read data and error pulses return to the granted requester one cycle later.
//
// Handshake: a requester holds req/we/adr/wdata until it sees gnt high in a
// cycle; that cycle is the transfer. rvalid/err are one-cycle pulses in the
// following cycle. rdata holds until the next rvalid.
//
// Ports
//   clk, rst_n                  clock, async active-low reset
//   h_* / n_*                   host / NPU request side (req, we, adr, wdata,
//                               gnt, rvalid, rdata, err); n_lock asks to keep
//                               the grant across cycles
//   ram_mem_adr, ram_reg_adr,
//   ram_din, ram_we             memory command (address/data hold when idle)
//   ram_dout                    memory read data, valid one cycle after command
module ann_mem_arbiter #(
    parameter int WIDTH    = 21,
    parameter int MEMSEL_W = 6,
    parameter int REGSEL_W = 11,
    parameter int DEPTH    = 1024,
    parameter int MEM_ADDR = 0,
    parameter int MAX_LOCK = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         h_req,
    input  logic                         h_we,
    input  logic [MEMSEL_W+REGSEL_W-1:0] h_adr,
    input  logic [WIDTH-1:0]             h_wdata,
    input  logic                         n_req,
    input  logic                         n_we,
    input  logic [MEMSEL_W+REGSEL_W-1:0] n_adr,
    input  logic [WIDTH-1:0]             n_wdata,
    input  logic                         n_lock,
    output logic                         h_gnt,
    output logic                         n_gnt,
    output logic                         h_rvalid,
    output logic                         n_rvalid,
    output logic [WIDTH-1:0]             h_rdata,
    output logic [WIDTH-1:0]             n_rdata,
    output logic                         h_err,
    output logic                         n_err,
    output logic [MEMSEL_W-1:0]          ram_mem_adr,
    output logic [REGSEL_W-1:0]          ram_reg_adr,
    output logic [WIDTH-1:0]             ram_din,
    output logic                         ram_we,
    input  logic [WIDTH-1:0]             ram_dout
);

    localparam int AW = MEMSEL_W + REGSEL_W;
    localparam int CW = $clog2(MAX_LOCK + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_LOCK);

    typedef enum logic {ST_RR, ST_LOCK} state_t;

    state_t          state;
    logic            last_npu;   // 1: NPU was granted last, 0: host
    logic [CW-1:0]   lock_cnt;
    logic            host_prio;  // host owed a grant after a MAX_LOCK exit
    logic [CW-1:0]   lock_cnt_nxt;

    logic [MEMSEL_W-1:0] mem_adr_q;
    logic [REGSEL_W-1:0] reg_adr_q;
    logic [WIDTH-1:0]    din_q;

    logic            h_from_ram, n_from_ram;  // rdata must come from ram_dout this cycle
    logic [WIDTH-1:0] h_rdata_q, n_rdata_q;

    logic            g_any, sel_we, in_range;
    logic [AW-1:0]   sel_adr;
    logic [WIDTH-1:0] sel_wdata;
    logic [MEMSEL_W-1:0] sel_memsel;
    logic [REGSEL_W-1:0] sel_regsel;

    // Grant decision. Reset forces both grants low.
    always_comb begin
        h_gnt = 1'b0;
        n_gnt = 1'b0;
        if (!rst_n) begin
            h_gnt = 1'b0;
            n_gnt = 1'b0;
        end else if (state == ST_LOCK) begin
            n_gnt = n_req;
        end else if (host_prio && h_req) begin
            h_gnt = 1'b1;
        end else if (h_req && n_req) begin
            h_gnt = last_npu;
            n_gnt = !last_npu;
        end else begin
            h_gnt = h_req;
            n_gnt = n_req;
        end
    end

    assign g_any      = h_gnt | n_gnt;
    assign sel_adr    = h_gnt ? h_adr   : n_adr;
    assign sel_wdata  = h_gnt ? h_wdata : n_wdata;
    assign sel_we     = h_gnt ? h_we    : n_we;
    assign sel_memsel = sel_adr[AW-1:REGSEL_W];
    assign sel_regsel = sel_adr[REGSEL_W-1:0];
    // Compare at 32 bits so DEPTH == 2**REGSEL_W does not wrap to zero.
    assign in_range   = (32'(sel_memsel) == 32'(MEM_ADDR)) &&
                        (32'(sel_regsel) < 32'(DEPTH));

    // Address/data follow the winner combinationally and hold when idle.
    assign ram_mem_adr = g_any ? sel_memsel : mem_adr_q;
    assign ram_reg_adr = g_any ? sel_regsel : reg_adr_q;
    assign ram_din     = g_any ? sel_wdata  : din_q;
    assign ram_we      = g_any & sel_we & in_range;

    assign h_rdata = h_from_ram ? ram_dout : h_rdata_q;
    assign n_rdata = n_from_ram ? ram_dout : n_rdata_q;

    assign lock_cnt_nxt = (n_gnt && lock_cnt < CNT_MAX) ? lock_cnt + 1'b1 : lock_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_RR;
            last_npu   <= 1'b0;
            lock_cnt   <= '0;
            host_prio  <= 1'b0;
            mem_adr_q  <= '0;
            reg_adr_q  <= '0;
            din_q      <= '0;
            h_rvalid   <= 1'b0;
            n_rvalid   <= 1'b0;
            h_err      <= 1'b0;
            n_err      <= 1'b0;
            h_from_ram <= 1'b0;
            n_from_ram <= 1'b0;
            h_rdata_q  <= '0;
            n_rdata_q  <= '0;
        end else begin
            if (g_any) begin
                mem_adr_q <= sel_memsel;
                reg_adr_q <= sel_regsel;
                din_q     <= sel_wdata;
                last_npu  <= n_gnt;
            end

            host_prio <= 1'b0;
            case (state)
                ST_RR: begin
                    lock_cnt <= '0;
                    if (n_gnt && n_lock) begin
                        if (MAX_LOCK <= 1) begin
                            host_prio <= h_req;
                        end else begin
                            state    <= ST_LOCK;
                            lock_cnt <= CW'(1);
                        end
                    end
                end
                ST_LOCK: begin
                    if (!n_lock || !n_req || lock_cnt_nxt == CNT_MAX) begin
                        state     <= ST_RR;
                        lock_cnt  <= '0;
                        host_prio <= (lock_cnt_nxt == CNT_MAX) && h_req;
                    end else begin
                        lock_cnt <= lock_cnt_nxt;
                    end
                end
                default: begin
                    state    <= ST_RR;
                    lock_cnt <= '0;
                end
            endcase

            // Response pulses for accesses granted this cycle.
            h_rvalid   <= h_gnt & ~h_we;
            n_rvalid   <= n_gnt & ~n_we;
            h_err      <= h_gnt & ~in_range;
            n_err      <= n_gnt & ~in_range;
            h_from_ram <= h_gnt & ~h_we & in_range;
            n_from_ram <= n_gnt & ~n_we & in_range;

            // A new out-of-range read overrides capture of the previous read.
            if (h_gnt && !h_we && !in_range) h_rdata_q <= '0;
            else if (h_from_ram)             h_rdata_q <= ram_dout;
            if (n_gnt && !n_we && !in_range) n_rdata_q <= '0;
            else if (n_from_ram)             n_rdata_q <= ram_dout;
        end
    end

endmodule

// File: tb/tb_ann_mem_arbiter.sv
module tb_ann_mem_arbiter;

    localparam int W  = 21;
    localparam int MW = 6;
    localparam int RW = 11;
    localparam int AW = MW + RW;

    typedef struct packed {
        logic [31:0]  cyc;
        logic         err;
        logic         rv;
        logic [W-1:0] d;
    } resp_t;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          h_req = 0, h_we = 0, n_req = 0, n_we = 0, n_lock = 0;
    logic [AW-1:0] h_adr = '0, n_adr = '0;
    logic [W-1:0]  h_wdata = '0, n_wdata = '0;
    logic          h_gnt, n_gnt, h_rvalid, n_rvalid, h_err, n_err, ram_we;
    logic [W-1:0]  h_rdata, n_rdata, ram_din, ram_dout;
    logic [MW-1:0] ram_mem_adr;
    logic [RW-1:0] ram_reg_adr;

    ann_mem_arbiter #(
        .WIDTH(W), .MEMSEL_W(MW), .REGSEL_W(RW),
        .DEPTH(1024), .MEM_ADDR(0), .MAX_LOCK(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .h_req(h_req), .h_we(h_we), .h_adr(h_adr), .h_wdata(h_wdata),
        .n_req(n_req), .n_we(n_we), .n_adr(n_adr), .n_wdata(n_wdata),
        .n_lock(n_lock),
        .h_gnt(h_gnt), .n_gnt(n_gnt),
        .h_rvalid(h_rvalid), .n_rvalid(n_rvalid),
        .h_rdata(h_rdata), .n_rdata(n_rdata),
        .h_err(h_err), .n_err(n_err),
        .ram_mem_adr(ram_mem_adr), .ram_reg_adr(ram_reg_adr),
        .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
    );

    // Behavioural memory: read-before-write, one-cycle latency.
    logic [W-1:0] mem [1024];
    always @(posedge clk) begin
        ram_dout <= mem[ram_reg_adr[9:0]];
        if (ram_we) mem[ram_reg_adr[9:0]] <= ram_din;
    end

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int compared = 0;
    int failed   = 0;
    resp_t hq[$];
    resp_t nq[$];
    logic [AW-1:0] last_adr = '0;
    logic [W-1:0]  last_din = '0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [AW-1:0] mk_adr(input int ms, input int rs);
        logic [MW-1:0] m;
        logic [RW-1:0] r;
        m = MW'(ms);
        r = RW'(rs);
        return {m, r};
    endfunction

    // driver tasks
    task automatic set_h(input logic req, input logic we, input logic [AW-1:0] adr,
                         input logic [W-1:0] wd);
        h_req = req; h_we = we; h_adr = adr; h_wdata = wd;
    endtask

    task automatic set_n(input logic req, input logic we, input logic [AW-1:0] adr,
                         input logic [W-1:0] wd, input logic lock);
        n_req = req; n_we = we; n_adr = adr; n_wdata = wd; n_lock = lock;
    endtask

    task automatic push_h(input logic err, input logic rv, input logic [W-1:0] d);
        hq.push_back('{cyc: cyc + 1, err: err, rv: rv, d: d});
    endtask

    task automatic push_n(input logic err, input logic rv, input logic [W-1:0] d);
        nq.push_back('{cyc: cyc + 1, err: err, rv: rv, d: d});
    endtask

    // Called just after a negedge with inputs set; checks the grant cycle and
    // advances to the next negedge.
    task automatic step(input logic eh, input logic en, input logic ewe, input string nm);
        logic [AW-1:0] ea;
        logic [W-1:0]  ed;
        #2;
        check({nm, "_gnt"}, 64'({h_gnt, n_gnt}), 64'({eh, en}));
        check({nm, "_we"}, 64'(ram_we), 64'(ewe));
        ea = eh ? h_adr : (en ? n_adr : last_adr);
        ed = eh ? h_wdata : (en ? n_wdata : last_din);
        check({nm, "_ram_cmd"}, 64'({ram_mem_adr, ram_reg_adr, ram_din}), 64'({ea, ed}));
        if (eh || en) begin
            last_adr = ea;
            last_din = ed;
        end
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string nm);
        check(nm, 64'({h_gnt, n_gnt, h_rvalid, n_rvalid, h_err, n_err, ram_we}), 64'(0));
        check({nm, "_data"}, 64'({h_rdata, n_rdata}), 64'(0));
        check({nm, "_ram"}, 64'({ram_mem_adr, ram_reg_adr, ram_din}), 64'(0));
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        resp_t e;
        if (h_rvalid || h_err) begin
            compared++;
            if (hq.size() == 0) begin
                failed++;
                $display("FAIL h_unexpected: rv=%0b err=%0b rdata=%0h expected no response (cycle %0d)",
                         h_rvalid, h_err, h_rdata, cyc);
            end else begin
                e = hq.pop_front();
                if (e.cyc != cyc || e.err !== h_err || e.rv !== h_rvalid || (e.rv && e.d !== h_rdata)) begin
                    failed++;
                    $display("FAIL h_resp: cycle %0d rv=%0b err=%0b rdata=%0h expected cycle %0d rv=%0b err=%0b rdata=%0h",
                             cyc, h_rvalid, h_err, h_rdata, e.cyc, e.rv, e.err, e.d);
                end
            end
        end
        if (n_rvalid || n_err) begin
            compared++;
            if (nq.size() == 0) begin
                failed++;
                $display("FAIL n_unexpected: rv=%0b err=%0b rdata=%0h expected no response (cycle %0d)",
                         n_rvalid, n_err, n_rdata, cyc);
            end else begin
                e = nq.pop_front();
                if (e.cyc != cyc || e.err !== n_err || e.rv !== n_rvalid || (e.rv && e.d !== n_rdata)) begin
                    failed++;
                    $display("FAIL n_resp: cycle %0d rv=%0b err=%0b rdata=%0h expected cycle %0d rv=%0b err=%0b rdata=%0h",
                             cyc, n_rvalid, n_err, n_rdata, e.cyc, e.rv, e.err, e.d);
                end
            end
        end
    end

    initial begin
        // reset state
        #1;
        check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // host write then read back, first cycle after reset
        set_h(1, 1, mk_adr(0, 5), 21'h1ABCDE);
        step(1, 0, 1, "h_wr5");
        set_h(1, 0, mk_adr(0, 5), '0);
        push_h(0, 1, 21'h1ABCDE);
        step(1, 0, 0, "h_rd5");

        // preload two more words
        set_h(0, 0, '0, '0);
        set_n(1, 1, mk_adr(0, 6), 21'h0AAAAA, 0);
        step(0, 1, 1, "n_wr6");
        set_n(0, 0, '0, '0, 0);
        set_h(1, 1, mk_adr(0, 7), 21'h155555);
        step(1, 0, 1, "h_wr7");

        // contention: host granted last, so N,H,N,H,N,H
        for (int i = 0; i < 6; i++) begin
            set_h(1, 0, mk_adr(0, 7), '0);
            set_n(1, 0, mk_adr(0, 6), '0, 0);
            if (i % 2 == 0) begin
                push_n(0, 1, 21'h0AAAAA);
                step(0, 1, 0, "rr_n");
            end else begin
                push_h(0, 1, 21'h155555);
                step(1, 0, 0, "rr_h");
            end
        end

        // read then write same address: read sees old data
        set_n(0, 0, '0, '0, 0);
        set_h(1, 0, mk_adr(0, 5), '0);
        push_h(0, 1, 21'h1ABCDE);
        step(1, 0, 0, "raw_rd");
        set_h(0, 0, '0, '0);
        set_n(1, 1, mk_adr(0, 5), 21'h000777, 0);
        step(0, 1, 1, "raw_wr");
        set_n(0, 0, '0, '0, 0);
        set_h(1, 0, mk_adr(0, 5), '0);
        push_h(0, 1, 21'h000777);
        step(1, 0, 0, "raw_rd2");

        // lock: 16 NPU grants, forced host grant, then alternation
        for (int i = 0; i < 20; i++) begin
            set_h(1, 0, mk_adr(0, 7), '0);
            set_n(1, 0, mk_adr(0, 6), '0, (i <= 16));
            if (i < 16 || i == 17 || i == 19) begin
                push_n(0, 1, 21'h0AAAAA);
                step(0, 1, 0, "lock_n");
            end else begin
                push_h(0, 1, 21'h155555);
                step(1, 0, 0, "lock_h");
            end
        end

        // out-of-range accesses
        set_h(0, 0, '0, '0);
        set_n(1, 0, mk_adr(0, 1024), '0, 0);
        push_n(1, 1, '0);
        step(0, 1, 0, "oor_rd_reg");
        set_n(1, 1, mk_adr(1, 5), 21'h0F0F0F, 0);
        push_n(1, 0, '0);
        step(0, 1, 0, "oor_wr_mem");
        set_n(1, 1, mk_adr(0, 1029), 21'h0F0F0F, 0);
        push_n(1, 0, '0);
        step(0, 1, 0, "oor_wr_reg");
        set_n(1, 0, mk_adr(1, 5), '0, 0);
        push_n(1, 1, '0);
        step(0, 1, 0, "oor_rd_mem");
        set_n(0, 0, '0, '0, 0);
        set_h(1, 0, mk_adr(0, 5), '0);
        push_h(0, 1, 21'h000777);
        step(1, 0, 0, "oor_unchanged");

        set_h(0, 0, '0, '0);
        step(0, 0, 0, "idle");

        // reset right after a granted read: its response must vanish
        set_h(1, 0, mk_adr(0, 6), '0);
        #2;
        check("pre_rst_gnt", 64'({h_gnt, n_gnt}), 64'(2'b10));
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        @(negedge clk);
        set_h(0, 0, '0, '0);
        @(negedge clk);
        rst_n = 1'b1;
        last_adr = '0;
        last_din = '0;

        // first access after release; pointer back at host so NPU wins
        set_h(1, 0, mk_adr(0, 7), '0);
        set_n(1, 0, mk_adr(0, 6), '0, 0);
        push_n(0, 1, 21'h0AAAAA);
        step(0, 1, 0, "post_rst_n");
        push_h(0, 1, 21'h155555);
        step(1, 0, 0, "post_rst_h");

        set_h(0, 0, '0, '0);
        set_n(0, 0, '0, '0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, "tail");

        check("h_queue_empty", 64'(hq.size()), 64'(0));
        check("n_queue_empty", 64'(nq.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
